// File: rtl/mem_pkg.sv
// Shared definitions for the store sequencer: size encodings, FSM states, byte-count helper.
package mem_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FIN   = 2'd2
    } state_t;

    // Reserved encoding 2'b11 behaves as a word store.
    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/store_byte_sel.sv
// Picks the idx-th big-endian byte of the sized store data (byte uses [7:0], half uses [15:0]).
module store_byte_sel
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        size,
    input  logic [1:0]        idx,
    output logic [7:0]        byte_o
);

    always_comb begin
        byte_o = data[7:0];
        case (size)
            SZ_BYTE: byte_o = data[7:0];
            SZ_HALF: byte_o = idx[0] ? data[7:0] : data[15:8];
            default: begin
                case (idx)
                    2'd0:    byte_o = data[31:24];
                    2'd1:    byte_o = data[23:16];
                    2'd2:    byte_o = data[15:8];
                    default: byte_o = data[7:0];
                endcase
            end
        endcase
    end

endmodule

// File: rtl/store_sequencer.sv
// Serialises one byte/half/word store into a byte-wide RAM, big-endian, one byte per cycle.
// Optional STORE_ALIGN_CHK_EN rejects misaligned half/word stores with an Err pulse.
//
// Handshake: Start is sampled only on an edge where the sequencer is in IDLE or FIN;
// Busy covers every cycle from the accepting edge through the Done cycle; Done (and Err)
// are single-cycle pulses; RamAddr/RamByte are meaningful only while RamWE=1.
module store_sequencer
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
)(
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        Size,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [7:0]        RamByte,
    output logic              RamWE,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output state_t            dbg_state
);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_byte_q, ram_byte_d;
    logic              ram_we_q, ram_we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] sel_data;
    logic [1:0]        sel_size;
    logic [1:0]        sel_idx;
    logic [7:0]        sel_byte;
    logic [2:0]        n_minus;
    logic              misalign;

    // Outputs are registered, so the selector looks one byte ahead: the incoming
    // request's first byte when accepting, else the next byte of the latched store.
    always_comb begin
        if (state_q == WRITE) begin
            sel_data = data_q;
            sel_size = size_q;
            sel_idx  = cnt_q + 2'd1;
        end else begin
            sel_data = WData;
            sel_size = Size;
            sel_idx  = 2'd0;
        end
    end

    store_byte_sel u_byte_sel (
        .data   (sel_data),
        .size   (sel_size),
        .idx    (sel_idx),
        .byte_o (sel_byte)
    );

    always_comb begin
`ifdef STORE_ALIGN_CHK_EN
        misalign = ((Size == SZ_HALF) && Addr[0]) || (Size[1] && (Addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        addr_d     = addr_q;
        data_d     = data_q;
        size_d     = size_q;
        ram_addr_d = ram_addr_q;
        ram_byte_d = ram_byte_q;
        ram_we_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        n_minus    = size_to_n(Size) - 3'd1;

        case (state_q)
            WRITE: begin
                busy_d = 1'b1;
                if (cnt_q == last_q) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 2'd1;
                    ram_we_d   = 1'b1;
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                    ram_byte_d = sel_byte;
                end
            end
            default: begin
                // IDLE and FIN both accept a request, which allows back-to-back stores.
                state_d = IDLE;
                busy_d  = 1'b0;
                if (Start) begin
                    addr_d = Addr;
                    data_d = WData;
                    size_d = Size;
                    last_d = n_minus[1:0];
                    cnt_d  = 2'd0;
                    busy_d = 1'b1;
                    if (misalign) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = WRITE;
                        ram_we_d   = 1'b1;
                        ram_addr_d = Addr;
                        ram_byte_d = sel_byte;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            addr_q     <= '0;
            data_q     <= '0;
            size_q     <= SZ_BYTE;
            ram_addr_q <= '0;
            ram_byte_q <= 8'd0;
            ram_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            size_q     <= size_d;
            ram_addr_q <= ram_addr_d;
            ram_byte_q <= ram_byte_d;
            ram_we_q   <= ram_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign RamAddr   = ram_addr_q;
    assign RamByte   = ram_byte_q;
    assign RamWE     = ram_we_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer: vector table plus hand sequences for reset/overlap/wrap/alignment.
module tb_store_sequencer;
    import mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ram_addr;
    logic [7:0]  ram_byte;
    logic        ram_we;
    logic        busy;
    logic        done;
    logic        err;
    state_t      dbg_state;

    int passed = 0;
    int total  = 0;

    store_sequencer #(.ADDR_W(32)) dut (
        .CLK       (clk),
        .Reset     (rst),
        .Start     (start),
        .Size      (size),
        .Addr      (addr),
        .WData     (wdata),
        .RamAddr   (ram_addr),
        .RamByte   (ram_byte),
        .RamWE     (ram_we),
        .Busy      (busy),
        .Done      (done),
        .Err       (err),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       sz;
        logic [31:0]      a;
        logic [31:0]      d;
        logic [2:0]       n;
        logic [3:0][7:0]  eb;
        logic [3:0][31:0] ea;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Present a request for one edge, then scramble the inputs to show they are not re-read.
    task automatic drive_start(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        start = 1'b1;
        size  = sz;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        size  = 2'($urandom_range(0, 3));
        addr  = $urandom;
        wdata = $urandom;
    endtask

    task automatic expect_write(input string name, input logic [31:0] a, input logic [7:0] b);
        @(negedge clk);
        check({name, "_we"},   32'(ram_we), 32'd1);
        check({name, "_addr"}, ram_addr, a);
        check({name, "_byte"}, 32'(ram_byte), 32'(b));
        check({name, "_busy"}, 32'(busy), 32'd1);
        check({name, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic expect_done(input string name, input logic exp_err);
        @(negedge clk);
        check({name, "_we"},    32'(ram_we), 32'd0);
        check({name, "_done"},  32'(done), 32'd1);
        check({name, "_busy"},  32'(busy), 32'd1);
        check({name, "_err"},   32'(err), 32'(exp_err));
        check({name, "_state"}, 32'(dbg_state), 32'(FIN));
    endtask

    task automatic expect_idle(input string name);
        @(negedge clk);
        check({name, "_we"},   32'(ram_we), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_err"},  32'(err), 32'd0);
    endtask

    initial begin
        vecs[0] = '{SZ_WORD, 32'h10, 32'hAABBCCDD, 3'd4,
                    {8'hAA, 8'hBB, 8'hCC, 8'hDD},
                    {32'h10, 32'h11, 32'h12, 32'h13}};
        vecs[1] = '{SZ_HALF, 32'h22, 32'h1234ABCD, 3'd2,
                    {8'hAB, 8'hCD, 8'h00, 8'h00},
                    {32'h22, 32'h23, 32'h0, 32'h0}};
        vecs[2] = '{SZ_BYTE, 32'h7, 32'h000000EE, 3'd1,
                    {8'hEE, 8'h00, 8'h00, 8'h00},
                    {32'h7, 32'h0, 32'h0, 32'h0}};
        vecs[3] = '{2'b11, 32'h30, 32'h11223344, 3'd4,
                    {8'h11, 8'h22, 8'h33, 8'h44},
                    {32'h30, 32'h31, 32'h32, 32'h33}};

        rst   = 1'b1;
        start = 1'b0;
        size  = SZ_BYTE;
        addr  = 32'h0;
        wdata = 32'h0;
        #12;
        check("rst_addr",  ram_addr, 32'h0);
        check("rst_byte",  32'(ram_byte), 32'h0);
        check("rst_we",    32'(ram_we), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            drive_start(vecs[v].sz, vecs[v].a, vecs[v].d);
            for (int k = 0; k < int'(vecs[v].n); k++)
                expect_write($sformatf("v%0d_b%0d", v, k), vecs[v].ea[3-k], vecs[v].eb[3-k]);
            expect_done($sformatf("v%0d_fin", v), 1'b0);
            expect_idle($sformatf("v%0d_idle", v));
        end

        // Start re-pulsed mid-store is dropped; Start on the FIN edge begins the next store.
        drive_start(SZ_WORD, 32'h60, 32'h0A0B0C0D);
        expect_write("ign_b0", 32'h60, 8'h0A);
        start = 1'b1;
        size  = SZ_BYTE;
        addr  = 32'h40;
        wdata = 32'hFFFFFFFF;
        expect_write("ign_b1", 32'h61, 8'h0B);
        start = 1'b0;
        expect_write("ign_b2", 32'h62, 8'h0C);
        expect_write("ign_b3", 32'h63, 8'h0D);
        expect_done("ign_fin", 1'b0);
        start = 1'b1;
        size  = SZ_BYTE;
        addr  = 32'h50;
        wdata = 32'h00000099;
        @(posedge clk);
        #1;
        start = 1'b0;
        expect_write("b2b_b0", 32'h50, 8'h99);
        expect_done("b2b_fin", 1'b0);
        expect_idle("b2b_idle");

`ifdef STORE_ALIGN_CHK_EN
        drive_start(SZ_WORD, 32'h11, 32'hCAFEF00D);
        expect_done("mis_word_fin", 1'b1);
        expect_idle("mis_word_idle");
        drive_start(SZ_HALF, 32'h23, 32'h00001234);
        expect_done("mis_half_fin", 1'b1);
        expect_idle("mis_half_idle");
        drive_start(SZ_WORD, 32'hFFFFFFFE, 32'h01020304);
        expect_done("mis_wrap_fin", 1'b1);
        expect_idle("mis_wrap_idle");
`else
        drive_start(SZ_WORD, 32'h11, 32'hCAFEF00D);
        expect_write("una_b0", 32'h11, 8'hCA);
        expect_write("una_b1", 32'h12, 8'hFE);
        expect_write("una_b2", 32'h13, 8'hF0);
        expect_write("una_b3", 32'h14, 8'h0D);
        expect_done("una_fin", 1'b0);
        expect_idle("una_idle");
        drive_start(SZ_WORD, 32'hFFFFFFFE, 32'h01020304);
        expect_write("wrap_b0", 32'hFFFFFFFE, 8'h01);
        expect_write("wrap_b1", 32'hFFFFFFFF, 8'h02);
        expect_write("wrap_b2", 32'h00000000, 8'h03);
        expect_write("wrap_b3", 32'h00000001, 8'h04);
        expect_done("wrap_fin", 1'b0);
        expect_idle("wrap_idle");
`endif

        // Reset during the second write cycle clears everything at once and suppresses Done.
        drive_start(SZ_WORD, 32'h80, 32'h55667788);
        expect_write("rmid_b0", 32'h80, 8'h55);
        expect_write("rmid_b1", 32'h81, 8'h66);
        rst = 1'b1;
        #1;
        check("rmid_addr",  ram_addr, 32'h0);
        check("rmid_byte",  32'(ram_byte), 32'h0);
        check("rmid_we",    32'(ram_we), 32'd0);
        check("rmid_busy",  32'(busy), 32'd0);
        check("rmid_done",  32'(done), 32'd0);
        check("rmid_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) expect_idle($sformatf("rmid_after%0d", c));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/store_sequencer.md
Name: store_sequencer

Overview:
Write-side counterpart of the CPU's clocked data-capture registers. Accepts one store request (byte/half/word) from the multicycle control path and serialises it into the byte-wide data RAM, one byte per cycle, big-endian. It signals completion so the control FSM can leave its MEM state.

Parameters:
ADDR_W, 32, width of byte address
DATA_W, 32, store data width; fixed at 32, not to be overridden

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  store request; sampled only while idle
Size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
Addr  in  ADDR_W  byte address of the store
WData  in  32  store data; a byte store uses [7:0], a half store uses [15:0]
RamAddr  out  ADDR_W  byte address to RAM
RamByte  out  8  byte to RAM
RamWE  out  1  RAM write enable; one byte is written per cycle it is high
Busy  out  1  sequencer occupied
Done  out  1  one-cycle completion pulse
Err  out  1  one-cycle misalignment pulse (only with STORE_ALIGN_CHK_EN)

Behaviour:
- Reset, asynchronous: state IDLE. RamAddr=0, RamByte=0, RamWE=0, Busy=0, Done=0, Err=0, byte counter=0. Internal latches are cleared.
- States are IDLE, WRITE and FIN.
- IDLE: on a rising edge with Start=1, latch Addr, WData and byte count N, then go to WRITE with counter i=0. Byte count N is 1 for a byte store, 2 for a half store, and 4 for a word or reserved store.
  - Busy goes high from this edge onward.
- WRITE: RamWE=1, RamAddr=AddrL+i, RamByte = the i-th big-endian byte of the sized data.
  - Word: [31:24], [23:16], [15:8], [7:0].
  - Half: [15:8], [7:0].
  - Byte: [7:0].
  - Each edge increments i. After the edge that completes byte N-1, go to FIN.
- FIN: RamWE=0, Done=1 and Busy=1 for exactly one cycle, then return to IDLE with Busy=0.
- Outputs are registered. The first RamWE cycle immediately follows the Start edge.
- Total latency from the Start edge to the Done cycle is N+1 cycles. A word store therefore occupies 5 cycles: 4 write cycles plus Done.
- Start while Busy=1 is ignored, not queued.
- Changes to Addr or WData after the Start edge have no effect.
- A new Start may be sampled on the edge leaving FIN, giving back-to-back stores with one idle-free gap.
- RamAddr increments wrap modulo 2^ADDR_W. Address 0xFFFFFFFF plus 1 gives 0.
- Reset asserted mid-WRITE aborts immediately. RAM bytes already written stay written, and no Done is produced.
- RamAddr and RamByte hold their last values in IDLE and FIN. Only RamWE qualifies them.

Optional Feature:
Macro name: STORE_ALIGN_CHK_EN
- Defined: a half store with Addr[0]=1, or a word store with Addr[1:0]!=0, does not enter WRITE.
  - The sequencer goes to FIN with Err=1 and Done=1 for one cycle.
  - Busy is high only in that cycle, and no RAM write occurs.
- Undefined: no check is made. Low address bits are used as given and Err is tied 0.

Decomposition:
- Shared package mem_pkg holds:
  - Size encodings: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - The state enum: IDLE, WRITE, FIN.
  - The byte-count function size_to_n.
- One sub-module is natural: store_byte_sel. It is purely combinational and maps latched data, Size and i to RamByte. The FSM and counter stay in the top module.

Test Plan:
- Reset mid-word: Reset during the 2nd write cycle -> all outputs 0 immediately, Busy=0, and no Done pulse.
- Word store, Addr=0x10, WData=0xAABBCCDD -> writes AA@0x10, BB@0x11, CC@0x12, DD@0x13 on consecutive cycles, then Done on cycle 5.
- Half and byte stores:
  - Half store, Addr=0x22, WData=0x1234ABCD -> AB@0x22, CD@0x23, then Done.
  - Byte store, Addr=0x7, WData=0x000000EE -> EE@0x7 only, with Done on cycle 2.
- Ignored Start: Start re-pulsed with Addr=0x40 during a word store -> ignored, and no write to 0x40. Start asserted on the FIN edge -> the second store begins on the next cycle.
- Wrap: word store at Addr=0xFFFFFFFE (checker off) -> writes to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- With STORE_ALIGN_CHK_EN: word store at Addr=0x11 -> Err=1 and Done=1 for one cycle, RamWE never asserted. The same case without the macro writes 4 bytes starting at 0x11.
